// File: rtl/rns_stack_core.sv
// rtl/rns_stack_core.sv - stack-machine core with residue-number-system add/multiply ALU
// Data stack lives in mem_q[0..count-1]; tos_q/nos_q shadow the top two entries.
module rns_stack_core #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 128,
   parameter int M1    = 37,
   parameter int M2    = 41,
   parameter int M3    = 43
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cmd_valid_i,
   output logic                       cmd_ready_o,
   input  logic [3:0]                 cmd_i,
   input  logic [WIDTH-1:0]           cmd_data_i,
   output logic [WIDTH-1:0]           tos_o,
   output logic [WIDTH-1:0]           nos_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       done_o,
   output logic                       err_underflow_o,
   output logic                       err_overflow_o,
   output logic                       err_illegal_o
);

   localparam int CNTW = $clog2(DEPTH+1);
   localparam int IW   = $clog2(DEPTH);
   localparam int CW   = 2*WIDTH + 2;
   localparam int MT   = M1*M2*M3;

   localparam logic [3:0] OP_NOP = 4'd0, OP_PUSH = 4'd1, OP_POP = 4'd2, OP_ADD = 4'd3,
                          OP_MUL = 4'd4, OP_DUP = 4'd5, OP_SWAP = 4'd6, OP_OVER = 4'd7,
                          OP_CLRERR = 4'd8;

   function automatic int inv_mod(input int a, input int m);
      int r;
      r = 0;
      for (int i = 1; i < m; i++) begin
         if ((a*i) % m == 1) r = i;
      end
      return r;
   endfunction

   // CRT basis: C_i = (M/M_i) * inverse(M/M_i mod M_i), each below M.
   localparam int C1 = (MT/M1) * inv_mod((MT/M1) % M1, M1);
   localparam int C2 = (MT/M2) * inv_mod((MT/M2) % M2, M2);
   localparam int C3 = (MT/M3) * inv_mod((MT/M3) % M3, M3);

   function automatic logic [CW-1:0] red(input logic [CW-1:0] x, input int m);
      return x % CW'(m);
   endfunction

   function automatic logic [WIDTH-1:0] crt(input logic [CW-1:0] r1, input logic [CW-1:0] r2,
                                            input logic [CW-1:0] r3);
      logic [CW-1:0] s;
      s = red(r1 * CW'(C1), MT) + red(r2 * CW'(C2), MT) + red(r3 * CW'(C3), MT);
      return WIDTH'(red(s, MT));
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_MUL1, S_EXEC} state_t;

   state_t            state_q, state_d;
   logic              accept, retire;
   logic [3:0]        opc_q;
   logic [WIDTH-1:0]  data_q, tos_q, nos_q;
   logic [CNTW-1:0]   count_q;
   logic              done_q, eu_q, eo_q, ei_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [CW-1:0]     p1_q, p2_q, p3_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_o = 1'b0;
      accept      = 1'b0;
      retire      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               accept  = 1'b1;
               state_d = (cmd_i == OP_MUL && count_q >= CNTW'(2)) ? S_MUL1 : S_EXEC;
            end
         end
         S_MUL1: state_d = S_EXEC;
         S_EXEC: begin
            retire  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic [CW-1:0] a_w, b_w, s1, s2, s3, m1, m2, m3;
   assign a_w = CW'(tos_q);
   assign b_w = CW'(nos_q);
   assign s1  = red(red(a_w, M1) + red(b_w, M1), M1);
   assign s2  = red(red(a_w, M2) + red(b_w, M2), M2);
   assign s3  = red(red(a_w, M3) + red(b_w, M3), M3);
   assign m1  = red(red(a_w, M1) * red(b_w, M1), M1);
   assign m2  = red(red(a_w, M2) * red(b_w, M2), M2);
   assign m3  = red(red(a_w, M3) * red(b_w, M3), M3);

   logic [WIDTH-1:0] alu_res, below;
   logic [IW-1:0]    i0, i1, i2, i3;
   logic             under, over, illegal, ok;

   assign alu_res = (opc_q == OP_MUL) ? crt(p1_q, p2_q, p3_q) : crt(s1, s2, s3);
   assign i0      = IW'(count_q);
   assign i1      = IW'(count_q - CNTW'(1));
   assign i2      = IW'(count_q - CNTW'(2));
   assign i3      = IW'(count_q - CNTW'(3));
   assign below   = (count_q > CNTW'(2)) ? mem_q[i3] : '0;

   assign illegal = (opc_q > OP_CLRERR);
   assign under   = ((opc_q == OP_POP || opc_q == OP_DUP) && count_q == '0) ||
                    ((opc_q == OP_ADD || opc_q == OP_MUL || opc_q == OP_SWAP || opc_q == OP_OVER)
                     && count_q < CNTW'(2));
   assign over    = (opc_q == OP_PUSH || opc_q == OP_DUP || opc_q == OP_OVER) &&
                    count_q == CNTW'(DEPTH);
   assign ok      = !under && !over && !illegal;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         tos_q   <= '0;
         nos_q   <= '0;
         done_q  <= 1'b0;
         eu_q    <= 1'b0;
         eo_q    <= 1'b0;
         ei_q    <= 1'b0;
      end else begin
         done_q <= retire;
         if (accept) begin
            opc_q  <= cmd_i;
            data_q <= cmd_data_i;
         end
         if (state_q == S_MUL1) begin
            p1_q <= m1;
            p2_q <= m2;
            p3_q <= m3;
         end
         if (retire) begin
            if (opc_q == OP_CLRERR) begin
               eu_q <= 1'b0;
               eo_q <= 1'b0;
               ei_q <= 1'b0;
            end else begin
               if (under)   eu_q <= 1'b1;
               if (over)    eo_q <= 1'b1;
               if (illegal) ei_q <= 1'b1;
            end
            if (ok) begin
               case (opc_q)
                  OP_PUSH: begin
                     mem_q[i0] <= data_q;
                     tos_q     <= data_q;
                     nos_q     <= tos_q;
                     count_q   <= count_q + CNTW'(1);
                  end
                  OP_POP: begin
                     tos_q   <= nos_q;
                     nos_q   <= below;
                     count_q <= count_q - CNTW'(1);
                  end
                  OP_ADD, OP_MUL: begin
                     mem_q[i2] <= alu_res;
                     tos_q     <= alu_res;
                     nos_q     <= below;
                     count_q   <= count_q - CNTW'(1);
                  end
                  OP_DUP: begin
                     mem_q[i0] <= tos_q;
                     nos_q     <= tos_q;
                     count_q   <= count_q + CNTW'(1);
                  end
                  OP_SWAP: begin
                     mem_q[i1] <= nos_q;
                     mem_q[i2] <= tos_q;
                     tos_q     <= nos_q;
                     nos_q     <= tos_q;
                  end
                  OP_OVER: begin
                     mem_q[i0] <= nos_q;
                     tos_q     <= nos_q;
                     nos_q     <= tos_q;
                     count_q   <= count_q + CNTW'(1);
                  end
                  OP_NOP, OP_CLRERR: ;
                  default: ;
               endcase
            end
         end
      end
   end

   assign tos_o           = tos_q;
   assign nos_o           = nos_q;
   assign count_o         = count_q;
   assign empty_o         = (count_q == '0);
   assign full_o          = (count_q == CNTW'(DEPTH));
   assign done_o          = done_q;
   assign err_underflow_o = eu_q;
   assign err_overflow_o  = eo_q;
   assign err_illegal_o   = ei_q;

endmodule

// File: tb/tb_rns_stack_core.sv
// tb/tb_rns_stack_core.sv - directed bench for rns_stack_core (default and DEPTH=4 instances)
module tb_rns_stack_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [3:0]  cmd = 4'd0;
   logic [15:0] cmd_data = 16'd0;

   logic        ready_a, empty_a, full_a, done_a, uf_a, of_a, il_a;
   logic [15:0] tos_a, nos_a;
   logic [7:0]  count_a;
   logic        ready_b, empty_b, full_b, done_b, uf_b, of_b, il_b;
   logic [15:0] tos_b, nos_b;
   logic [2:0]  count_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rns_stack_core dut_a (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_a),
      .cmd_i(cmd), .cmd_data_i(cmd_data), .tos_o(tos_a), .nos_o(nos_a), .count_o(count_a),
      .empty_o(empty_a), .full_o(full_a), .done_o(done_a), .err_underflow_o(uf_a),
      .err_overflow_o(of_a), .err_illegal_o(il_a)
   );

   rns_stack_core #(.DEPTH(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_b),
      .cmd_i(cmd), .cmd_data_i(cmd_data), .tos_o(tos_b), .nos_o(nos_b), .count_o(count_b),
      .empty_o(empty_b), .full_o(full_b), .done_o(done_b), .err_underflow_o(uf_b),
      .err_overflow_o(of_b), .err_illegal_o(il_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one command and wait (bounded) for its done pulse; latency counted from the accept edge.
   task automatic exec(input logic [3:0] op, input logic [15:0] d, input bit sel_b, input int exp_lat);
      int   lat;
      int   busy;
      logic dn;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd       = op;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat  = 0;
      busy = 0;
      dn   = 1'b0;
      while (!dn && lat < 6) begin
         if (!(sel_b ? ready_b : ready_a)) busy++;
         @(negedge clk);
         lat++;
         dn = sel_b ? done_b : done_a;
      end
      check($sformatf("latency op%0d", op), lat, exp_lat);
      check($sformatf("ready_low op%0d", op), busy, exp_lat);
   endtask

   initial begin
      int seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst count", count_a, 0);
      check("rst tos", tos_a, 0);
      check("rst nos", nos_a, 0);
      check("rst empty", empty_a, 1);
      check("rst full", full_a, 0);
      check("rst done", done_a, 0);
      check("rst errs", {uf_a, of_a, il_a}, 0);
      check("rst ready", ready_a, 1);

      exec(4'd1, 16'd5, 0, 1);
      exec(4'd1, 16'd7, 0, 1);
      exec(4'd3, 16'd0, 0, 1);
      check("add tos", tos_a, 12);
      check("add count", count_a, 1);
      @(negedge clk);
      check("done width", done_a, 0);
      exec(4'd1, 16'd65230, 0, 1);
      exec(4'd1, 16'd2, 0, 1);
      exec(4'd3, 16'd0, 0, 1);
      check("add wrap tos", tos_a, 1);
      check("add wrap nos", nos_a, 12);
      exec(4'd2, 16'd0, 0, 1);
      exec(4'd2, 16'd0, 0, 1);
      check("drain empty", empty_a, 1);

      exec(4'd1, 16'd300, 0, 1);
      exec(4'd1, 16'd300, 0, 1);
      exec(4'd4, 16'd0, 0, 2);
      check("mul tos", tos_a, 24769);
      check("mul count", count_a, 1);
      exec(4'd1, 16'd65000, 0, 1);
      exec(4'd1, 16'd300, 0, 1);
      exec(4'd3, 16'd0, 0, 1);
      check("add big tos", tos_a, 69);
      exec(4'd1, 16'd65535, 0, 1);
      exec(4'd1, 16'd2, 0, 1);
      exec(4'd4, 16'd0, 0, 2);
      check("mul big tos", tos_a, 608);
      check("mul big nos", nos_a, 69);
      exec(4'd2, 16'd0, 0, 1);
      check("pop tos", tos_a, 69);
      check("pop nos", nos_a, 24769);
      exec(4'd2, 16'd0, 0, 1);
      exec(4'd2, 16'd0, 0, 1);
      check("empty again", count_a, 0);

      exec(4'd3, 16'd0, 0, 1);
      check("uflow add flag", uf_a, 1);
      check("uflow add count", count_a, 0);
      exec(4'd2, 16'd0, 0, 1);
      check("uflow sticky", uf_a, 1);
      exec(4'd8, 16'd0, 0, 1);
      check("clrerr", uf_a, 0);
      exec(4'd12, 16'd0, 0, 1);
      check("illegal flag", il_a, 1);
      check("illegal count", count_a, 0);
      exec(4'd4, 16'd0, 0, 1);
      check("uflow mul flag", uf_a, 1);
      exec(4'd8, 16'd0, 0, 1);
      check("clrerr all", {uf_a, of_a, il_a}, 0);

      exec(4'd1, 16'd1, 0, 1);
      exec(4'd1, 16'd2, 0, 1);
      exec(4'd6, 16'd0, 0, 1);
      check("swap tos", tos_a, 1);
      check("swap nos", nos_a, 2);
      exec(4'd7, 16'd0, 0, 1);
      check("over tos", tos_a, 2);
      check("over nos", nos_a, 1);
      check("over count", count_a, 3);
      exec(4'd2, 16'd0, 0, 1);
      check("pop after over tos", tos_a, 1);
      check("pop after over nos", nos_a, 2);
      exec(4'd2, 16'd0, 0, 1);
      exec(4'd2, 16'd0, 0, 1);
      check("pop3 empty", empty_a, 1);
      check("pop3 tos/nos", {tos_a, nos_a}, 0);

      exec(4'd1, 16'd3, 0, 1);
      exec(4'd1, 16'd4, 0, 1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd       = 4'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort ready", ready_a, 1);
      check("abort count", count_a, 0);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done_a) seen++;
      end
      check("abort no done", seen, 0);
      exec(4'd1, 16'd8, 0, 1);
      check("post abort tos", tos_a, 8);
      check("post abort count", count_a, 1);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("d4 rst count", count_b, 0);
      exec(4'd1, 16'd1, 1, 1);
      exec(4'd1, 16'd2, 1, 1);
      exec(4'd1, 16'd3, 1, 1);
      exec(4'd1, 16'd4, 1, 1);
      check("d4 full", full_b, 1);
      check("d4 tos", tos_b, 4);
      exec(4'd1, 16'd9, 1, 1);
      check("d4 overflow", of_b, 1);
      check("d4 ovf tos", tos_b, 4);
      check("d4 ovf count", count_b, 4);
      exec(4'd5, 16'd0, 1, 1);
      check("d4 dup count", count_b, 4);
      check("d4 dup nos", nos_b, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rns_stack_core.md
# rns_stack_core

Parametrised stack-machine execution core: a DEPTH-entry data stack with a registered command handshake and an ALU whose ADD and MUL are computed in residue number system arithmetic over three pairwise-coprime moduli. It replaces the fixed 128×16 stack, ALU and control unit with one clocked block. It adds:
- a valid/ready command interface;
- a two-cycle multiply;
- SWAP/OVER;
- sticky overflow, underflow and illegal-opcode flags.

It sits between the instruction fetch/decode logic, which issues commands, and any consumer of top-of-stack.

## Interface
- WIDTH, 16: data word width.
- DEPTH, 128: stack entries (≥2).
- M1, 37; M2, 41; M3, 43: RNS moduli.
  - Pairwise coprime.
  - M = M1·M2·M3 must satisfy M ≤ 2^WIDTH (default M = 65231).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  core can accept a command (high only in IDLE).
- cmd  in  4  opcode.
- cmd_data  in  WIDTH  operand for PUSH.
- tos  out  WIDTH  top of stack (0 when count=0).
- nos  out  WIDTH  next-on-stack (0 when count<2).
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty, full  out  1  count==0, count==DEPTH.
- done  out  1  one-cycle pulse when a command retires (including rejected ones).
- err_underflow, err_overflow, err_illegal  out  1  sticky error flags.

## Operation
- A command is accepted on a rising edge with cmd_valid & cmd_ready & ~rst. Commands presented while rst=1 are ignored.
- Opcodes (a = tos, b = nos):
  - 0 NOP.
  - 1 PUSH: push cmd_data unmodified.
  - 2 POP: drop a.
  - 3 ADD: pop a and b, push (b+a) mod M.
  - 4 MUL: pop a and b, push (b·a) mod M.
  - 5 DUP: push a.
  - 6 SWAP: exchange a and b.
  - 7 OVER: push b.
  - 8 CLRERR: clear all three error flags.
  - 9–15: illegal.
- Arithmetic:
  - Operands are reduced to residues (x mod Mi) per channel.
  - Channels are added or multiplied and reduced mod Mi.
  - The result is reconstructed by CRT to [0, M-1].
  - Results must equal the integer definition above for any WIDTH-bit operands, including operands ≥ M.
- Operand requirements:
  - POP, DUP: count ≥ 1.
  - ADD, MUL, SWAP, OVER: count ≥ 2.
  - If the requirement is not met: stack unchanged, err_underflow set, done still pulses.
- Net-growth ops (PUSH, DUP, OVER) with count == DEPTH: stack unchanged, err_overflow set, done pulses.
- Illegal opcode: stack unchanged, err_illegal set, done pulses.
- Error flags stay set until CLRERR or reset.
  - CLRERR takes priority over any error raised in the same retire (none possible from CLRERR itself).
- State machine:
  - IDLE: cmd_ready=1.
    - Accept MUL (with operands valid) → MUL1.
    - Accept any other command → EXEC.
  - EXEC: apply the stack update, done=1 → IDLE.
  - MUL1: register the per-channel residue products → EXEC, which reconstructs and writes the result.
  - A MUL rejected for underflow goes IDLE→EXEC directly.
- ADD's residue sum, CRT reconstruction and writeback complete within EXEC.

## Timing
- Reset (rst=1 at edge):
  - state=IDLE; count=0.
  - tos=nos=0; empty=1, full=0.
  - done=0; all error flags 0.
  - cmd_ready=1 from the first cycle after rst deasserts.
  - Stack memory contents are don't-care.
- Accept at edge N:
  - Non-MUL: done=1 and updated tos/nos/count/flags visible after edge N+1. cmd_ready is low for cycle N..N+1, high after N+1.
  - MUL: done after edge N+2. cmd_ready is low for two cycles.
- Maximum throughput: one non-MUL command per 2 cycles.
- done is high for exactly one cycle, coincident with the new outputs.
- rst in MUL1 or EXEC: the operation is abandoned, no done pulse, reset values apply.
- tos, nos, count, empty and full are registered and change only on a retiring edge or reset.

## Test plan
- Reset, PUSH 5, PUSH 7, ADD → tos=12, count=1, done exactly 1 cycle after ADD acceptance. Then PUSH 65230, PUSH 2, ADD → tos=1.
- PUSH 300, PUSH 300, MUL → cmd_ready low 2 cycles, done at N+2, tos=24769 (90000 mod 65231), count=1. Then PUSH 65000, PUSH 300, ADD → tos=69.
- Empty stack: ADD → err_underflow=1, count=0, done pulses. POP → flag stays 1. CLRERR → flag 0. Opcode 12 → err_illegal=1, stack unchanged.
- DEPTH=4 instance: PUSH 1..4 → full=1, tos=4. PUSH 9 → err_overflow=1, tos=4, count=4. DUP → still 4 entries.
- PUSH 1, PUSH 2, SWAP → tos=1, nos=2. OVER → tos=2, nos=1, count=3. POP ×3 → empty=1, tos=nos=0.
- PUSH 3, PUSH 4, MUL with rst asserted the cycle after acceptance → no done, count=0, cmd_ready=1 after release. A following PUSH 8 gives tos=8, count=1.
